// File: rtl/top_k_ctrl.sv
// top_k_ctrl: sequencer for a chain of K top-k cells.
// Each query goes through four steps. First the chain is cleared. Then one query
// stream is forwarded into the chain head. The controller waits until that stream
// drains out of the chain tail. Finally it snapshots the K cell registers and
// emits them as a K-beat result stream, largest value first. After the last
// result beat is taken, the controller clears the chain again for the next query.
//
// Handshake rule on every stream port: a beat transfers on a rising edge where
// TVALID and TREADY are both high. A source holds TVALID, TDATA and TLAST stable
// until that transfer happens. This block never lowers m_result_TVALID before
// the beat is accepted.
module top_k_ctrl #(
    parameter int K            = 8,
    parameter int INTEGER_SIZE = 32,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    // upstream query stream
    input  logic [INTEGER_SIZE-1:0]   s_data_TDATA,
    input  logic                      s_data_TVALID,
    input  logic                      s_data_TLAST,
    output logic                      s_data_TREADY,
    // chain head
    output logic                      chain_en,
    output logic                      chain_clear,
    output logic [INTEGER_SIZE-1:0]   chain_TDATA,
    output logic                      chain_TVALID,
    output logic                      chain_TLAST,
    input  logic                      chain_TREADY,
    // chain tail
    input  logic                      tail_TVALID,
    input  logic                      tail_TLAST,
    output logic                      tail_TREADY,
    // cell registers, cell i at [i*INTEGER_SIZE +: INTEGER_SIZE], cell 0 = maximum
    input  logic [K*INTEGER_SIZE-1:0] reg_TDATA,
    // result stream
    output logic [INTEGER_SIZE-1:0]   m_result_TDATA,
    output logic                      m_result_TVALID,
    output logic                      m_result_TLAST,
    input  logic                      m_result_TREADY,
    // status
    output logic [CNT_WIDTH-1:0]      elem_count,
    output logic                      busy,
    // debug view of the sequencer state (0 CLEAR, 1 STREAM, 2 DRAIN, 3 OUTPUT)
    output logic [1:0]                dbg_state
);

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_OUTPUT = 2'd3
    } state_t;

    localparam int IDX_W  = (K > 1) ? $clog2(K) : 1;
    localparam int WAIT_W = $clog2(2 * K + 3);

    // The clear pulse moves down the chain at 2 cycles per cell. The wait
    // counter therefore runs from 0 to 2*K+2 before the controller leaves CLEAR.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(2 * K + 2);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(K - 1);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [WAIT_W-1:0]       r_wait;
    logic                    r_en;
    logic [CNT_WIDTH-1:0]    r_run_cnt;
    logic [CNT_WIDTH-1:0]    r_elem_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [INTEGER_SIZE-1:0] r_snap [K];

    logic w_in_accept;
    logic w_tail_last;
    logic w_out_accept;
    logic w_out_last;
    logic w_clear_done;

    // Transfer qualifiers for each state.
    // A tail TLAST is looked at only in DRAIN. A stale one from the previous
    // query, arriving during CLEAR or STREAM, must not end the current query.
    assign w_in_accept  = (r_state == ST_STREAM) && s_data_TVALID && chain_TREADY;
    assign w_tail_last  = (r_state == ST_DRAIN) && tail_TVALID && tail_TLAST;
    assign w_out_accept = (r_state == ST_OUTPUT) && m_result_TREADY;
    assign w_out_last   = w_out_accept && (r_idx == IDX_LAST);
    assign w_clear_done = (r_state == ST_CLEAR) && r_en && (r_wait == WAIT_LAST);

    // State register.
    // r_en goes high on the first edge after reset is released. It drives both
    // chain_en and tail_TREADY, and it also marks the first CLEAR cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_CLEAR;
            r_en    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_en    <= 1'b1;
        end
    end

    // Clear wait counter.
    // It counts only while CLEAR is live and sits at 0 in every other state.
    // Because of that, each entry into CLEAR starts a new pulse with the counter at 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wait <= '0;
        end else if ((r_state == ST_CLEAR) && r_en && !w_clear_done) begin
            r_wait <= r_wait + 1'b1;
        end else begin
            r_wait <= '0;
        end
    end

    // Running element counter.
    // It is zeroed by CLEAR and saturates at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_run_cnt <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_run_cnt <= '0;
        end else if (w_in_accept && (r_run_cnt != {CNT_WIDTH{1'b1}})) begin
            r_run_cnt <= r_run_cnt + 1'b1;
        end
    end

    // Completed-query element count, loaded when the tail TLAST arrives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_elem_cnt <= '0;
        end else if (w_tail_last) begin
            r_elem_cnt <= r_run_cnt;
        end
    end

    // Result beat index.
    // It is set to 0 at capture, steps on each accepted beat, and wraps back to 0 after the last beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (w_tail_last) begin
            r_idx <= '0;
        end else if (w_out_accept) begin
            r_idx <= w_out_last ? '0 : (r_idx + 1'b1);
        end
    end

    // Snapshot of the cell registers, taken once per query.
    // Later changes in the cells do not reach the result stream.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < K; i++) begin
                r_snap[i] <= '0;
            end
        end else if (w_tail_last) begin
            for (int i = 0; i < K; i++) begin
                r_snap[i] <= reg_TDATA[i*INTEGER_SIZE +: INTEGER_SIZE];
            end
        end
    end

    // Next-state logic and all state-dependent outputs.
    always_comb begin
        w_next_state    = r_state;
        s_data_TREADY   = 1'b0;
        chain_TDATA     = '0;
        chain_TVALID    = 1'b0;
        chain_TLAST     = 1'b0;
        m_result_TDATA  = '0;
        m_result_TVALID = 1'b0;
        m_result_TLAST  = 1'b0;
        busy            = 1'b1;
        chain_clear     = 1'b0;

        case (r_state)
            ST_CLEAR: begin
                chain_clear = r_en && (r_wait == '0);
                if (w_clear_done) begin
                    w_next_state = ST_STREAM;
                end
            end
            ST_STREAM: begin
                s_data_TREADY = chain_TREADY;
                chain_TDATA   = s_data_TDATA;
                chain_TVALID  = s_data_TVALID;
                chain_TLAST   = s_data_TLAST;
                busy          = (r_run_cnt != '0);
                if (w_in_accept && s_data_TLAST) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_tail_last) begin
                    w_next_state = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                m_result_TDATA  = r_snap[r_idx];
                m_result_TVALID = 1'b1;
                m_result_TLAST  = (r_idx == IDX_LAST);
                if (w_out_last) begin
                    w_next_state = ST_CLEAR;
                end
            end
            default: begin
                w_next_state = ST_CLEAR;
            end
        endcase
    end

    assign chain_en    = r_en;
    assign tail_TREADY = r_en;
    assign elem_count  = r_elem_cnt;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_top_k_ctrl.sv
// Directed bench for top_k_ctrl with K=4.
// The bench itself plays the top-k chain. It drives reg_TDATA with the
// hand-sorted cell contents for each query and raises the tail TLAST once the
// query has been streamed in.
module tb_top_k_ctrl;

  localparam int K  = 4;
  localparam int W  = 32;
  localparam int CW = 32;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  s_data_TDATA;
  logic          s_data_TVALID;
  logic          s_data_TLAST;
  logic          s_data_TREADY;
  logic          chain_en;
  logic          chain_clear;
  logic [W-1:0]  chain_TDATA;
  logic          chain_TVALID;
  logic          chain_TLAST;
  logic          chain_TREADY;
  logic          tail_TVALID;
  logic          tail_TLAST;
  logic          tail_TREADY;
  logic [K*W-1:0] reg_TDATA;
  logic [W-1:0]  m_result_TDATA;
  logic          m_result_TVALID;
  logic          m_result_TLAST;
  logic          m_result_TREADY;
  logic [CW-1:0] elem_count;
  logic          busy;
  logic [1:0]    dbg_state;

  int n_vec = 0;
  int n_err = 0;

  top_k_ctrl #(.K(K), .INTEGER_SIZE(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data_TDATA(s_data_TDATA), .s_data_TVALID(s_data_TVALID),
    .s_data_TLAST(s_data_TLAST), .s_data_TREADY(s_data_TREADY),
    .chain_en(chain_en), .chain_clear(chain_clear),
    .chain_TDATA(chain_TDATA), .chain_TVALID(chain_TVALID),
    .chain_TLAST(chain_TLAST), .chain_TREADY(chain_TREADY),
    .tail_TVALID(tail_TVALID), .tail_TLAST(tail_TLAST), .tail_TREADY(tail_TREADY),
    .reg_TDATA(reg_TDATA),
    .m_result_TDATA(m_result_TDATA), .m_result_TVALID(m_result_TVALID),
    .m_result_TLAST(m_result_TLAST), .m_result_TREADY(m_result_TREADY),
    .elem_count(elem_count), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat. Return the number of cycles it stalled before acceptance.
  task automatic send_beat(input logic [W-1:0] d, input logic last, output int waits);
    waits = 0;
    s_data_TDATA  = d;
    s_data_TLAST  = last;
    s_data_TVALID = 1'b1;
    #1;
    while (s_data_TREADY !== 1'b1 && waits < 100) begin
      @(posedge clk);
      #2;
      waits++;
    end
    if (s_data_TREADY !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL send_beat_timeout: s_data_TREADY=%b required 1", s_data_TREADY);
    end
    @(posedge clk);
    #1;
    s_data_TVALID = 1'b0;
    s_data_TLAST  = 1'b0;
  endtask

  // Idle until the controller is ready for a new query.
  task automatic wait_ready(output int cyc);
    s_data_TVALID = 1'b0;
    cyc = 0;
    #1;
    while (s_data_TREADY !== 1'b1 && cyc < 100) begin
      step();
      cyc++;
    end
    if (s_data_TREADY !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL wait_ready_timeout: s_data_TREADY=%b required 1", s_data_TREADY);
    end
  endtask

  // Act as the chain tail: send one discarded beat, then a TLAST beat with the cell contents.
  task automatic drain(input logic [W-1:0] w0, input logic [W-1:0] w1,
                       input logic [W-1:0] w2, input logic [W-1:0] w3);
    reg_TDATA   = {w3, w2, w1, w0};
    tail_TVALID = 1'b1;
    tail_TLAST  = 1'b0;
    step();
    tail_TLAST = 1'b1;
    #1;
    n_vec++;
    if (m_result_TVALID !== 1'b0) begin
      n_err++;
      $display("FAIL drain_no_early_result: m_result_TVALID=%b required 0", m_result_TVALID);
    end
    step();
    tail_TVALID = 1'b0;
    tail_TLAST  = 1'b0;
    reg_TDATA   = ~{w3, w2, w1, w0};
  endtask

  // Take the K result beats using a per-cycle ready pattern, then confirm the chain is cleared again.
  task automatic expect_results(input string tag,
                                input logic [W-1:0] e0, input logic [W-1:0] e1,
                                input logic [W-1:0] e2, input logic [W-1:0] e3,
                                input logic [CW-1:0] exp_cnt, input logic [3:0] rdy_pat);
    logic [W-1:0] exp_v [4];
    int beat;
    int cyc;
    exp_v[0] = e0; exp_v[1] = e1; exp_v[2] = e2; exp_v[3] = e3;
    beat = 0;
    cyc  = 0;
    n_vec++;
    if (elem_count !== exp_cnt) begin
      n_err++;
      $display("FAIL %s elem_count: got %0d required %0d", tag, elem_count, exp_cnt);
    end
    while (beat < K && cyc < 64) begin
      m_result_TREADY = rdy_pat[cyc % 4];
      #1;
      n_vec++;
      if (m_result_TVALID !== 1'b1) begin
        n_err++;
        $display("FAIL %s valid beat%0d cyc%0d: got %b required 1", tag, beat, cyc, m_result_TVALID);
      end
      n_vec++;
      if (m_result_TDATA !== exp_v[beat]) begin
        n_err++;
        $display("FAIL %s data beat%0d cyc%0d: got %0d required %0d", tag, beat, cyc, m_result_TDATA, exp_v[beat]);
      end
      n_vec++;
      if (m_result_TLAST !== (beat == K - 1)) begin
        n_err++;
        $display("FAIL %s last beat%0d cyc%0d: got %b required %b", tag, beat, cyc, m_result_TLAST, (beat == K - 1));
      end
      if (m_result_TREADY) beat++;
      step();
      cyc++;
    end
    m_result_TREADY = 1'b1;
    if (beat < K) begin
      n_vec++; n_err++;
      $display("FAIL %s result_timeout: beats=%0d required %0d", tag, beat, K);
    end
    #1;
    n_vec++;
    if (chain_clear !== 1'b1 || m_result_TVALID !== 1'b0) begin
      n_err++;
      $display("FAIL %s reclear: chain_clear=%b valid=%b required 1 0", tag, chain_clear, m_result_TVALID);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int n;
    int extra;
    rst_n = 1'b0;
    repeat (3) step();
    s_data_TVALID = 1'b1;
    #1;
    n_vec++;
    if ({chain_en, chain_clear, s_data_TREADY, chain_TVALID, tail_TREADY} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctl: en/clr/rdy/cv/tr=%b required 00000",
               {chain_en, chain_clear, s_data_TREADY, chain_TVALID, tail_TREADY});
    end
    n_vec++;
    if ({m_result_TVALID, m_result_TLAST} !== 2'b0 || m_result_TDATA !== '0) begin
      n_err++;
      $display("FAIL reset_result: valid=%b last=%b data=%0d required 0 0 0",
               m_result_TVALID, m_result_TLAST, m_result_TDATA);
    end
    n_vec++;
    if (elem_count !== '0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL reset_status: elem_count=%0d busy=%b required 0 1", elem_count, busy);
    end
    s_data_TVALID = 1'b0;
    rst_n = 1'b1;
    step();
    n_vec++;
    if (chain_clear !== 1'b1 || chain_en !== 1'b1 || tail_TREADY !== 1'b1) begin
      n_err++;
      $display("FAIL clear_pulse: clear=%b en=%b tail_rdy=%b required 1 1 1", chain_clear, chain_en, tail_TREADY);
    end
    n = 0;
    extra = 0;
    while (n < 40) begin
      step();
      n++;
      if (chain_clear === 1'b1) extra++;
      if (s_data_TREADY === 1'b1) break;
    end
    n_vec++;
    if (n !== 2 * K + 3) begin
      n_err++;
      $display("FAIL ready_latency: got %0d cycles required %0d", n, 2 * K + 3);
    end
    n_vec++;
    if (extra !== 0) begin
      n_err++;
      $display("FAIL clear_single: extra clear cycles %0d required 0", extra);
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_busy: busy=%b required 0", busy);
    end
  endtask

  task automatic test_basic();
    int w;
    // the chain head should see the upstream fields directly
    chain_TREADY  = 1'b0;
    s_data_TDATA  = 32'hA5A5;
    s_data_TLAST  = 1'b1;
    s_data_TVALID = 1'b1;
    #1;
    n_vec++;
    if (chain_TDATA !== 32'hA5A5 || chain_TLAST !== 1'b1 || chain_TVALID !== 1'b1 || s_data_TREADY !== 1'b0) begin
      n_err++;
      $display("FAIL passthrough: data=%h last=%b valid=%b rdy=%b required a5a5 1 1 0",
               chain_TDATA, chain_TLAST, chain_TVALID, s_data_TREADY);
    end
    s_data_TVALID = 1'b0;
    s_data_TLAST  = 1'b0;
    chain_TREADY  = 1'b1;
    send_beat(5, 1'b0, w);
    #1;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL stream_busy: busy=%b required 1", busy);
    end
    send_beat(9, 1'b0, w);
    send_beat(1, 1'b0, w);
    send_beat(7, 1'b0, w);
    send_beat(3, 1'b0, w);
    send_beat(8, 1'b1, w);
    s_data_TDATA  = 99;
    s_data_TVALID = 1'b1;
    #1;
    n_vec++;
    if (s_data_TREADY !== 1'b0 || chain_TVALID !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL drain_block: rdy=%b cvalid=%b busy=%b required 0 0 1", s_data_TREADY, chain_TVALID, busy);
    end
    s_data_TVALID = 1'b0;
    drain(9, 8, 7, 5);
    expect_results("basic", 9, 8, 7, 5, 6, 4'b1111);
  endtask

  task automatic test_short();
    int w;
    wait_ready(w);
    // stale tail TLAST while streaming must be ignored
    reg_TDATA   = {32'd77, 32'd66, 32'd55, 32'd44};
    tail_TVALID = 1'b1;
    tail_TLAST  = 1'b1;
    step();
    tail_TVALID = 1'b0;
    tail_TLAST  = 1'b0;
    #1;
    n_vec++;
    if (s_data_TREADY !== 1'b1 || m_result_TVALID !== 1'b0) begin
      n_err++;
      $display("FAIL stale_tail_stream: rdy=%b valid=%b required 1 0", s_data_TREADY, m_result_TVALID);
    end
    send_beat(4, 1'b0, w);
    send_beat(2, 1'b1, w);
    drain(4, 2, 0, 0);
    expect_results("short", 4, 2, 0, 0, 2, 4'b1111);
  endtask

  task automatic test_backpressure();
    int w;
    wait_ready(w);
    send_beat(11, 1'b0, w);
    chain_TREADY  = 1'b0;
    s_data_TDATA  = 22;
    s_data_TVALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if (s_data_TREADY !== 1'b0) begin
        n_err++;
        $display("FAIL chain_stall cyc%0d: rdy=%b required 0", i, s_data_TREADY);
      end
      step();
    end
    chain_TREADY = 1'b1;
    send_beat(22, 1'b0, w);
    send_beat(33, 1'b1, w);
    drain(33, 22, 11, 0);
    expect_results("bp", 33, 22, 11, 0, 3, 4'b1001);
  endtask

  task automatic test_back_to_back();
    int w;
    wait_ready(w);
    send_beat(10, 1'b0, w);
    send_beat(20, 1'b1, w);
    drain(20, 10, 0, 0);
    expect_results("b2b_a", 20, 10, 0, 0, 2, 4'b1111);
    // B is offered during the clear pulse and must wait for the re-clear to finish
    send_beat(3, 1'b1, w);
    n_vec++;
    if (w !== 2 * K + 3) begin
      n_err++;
      $display("FAIL b2b_stall: stalled %0d cycles required %0d", w, 2 * K + 3);
    end
    drain(3, 0, 0, 0);
    expect_results("b2b_b", 3, 0, 0, 0, 1, 4'b1111);
  endtask

  task automatic test_mid_reset();
    int w;
    int n;
    int seen;
    wait_ready(w);
    send_beat(6, 1'b0, w);
    send_beat(5, 1'b0, w);
    send_beat(4, 1'b0, w);
    rst_n = 1'b0;
    step();
    #1;
    n_vec++;
    if (chain_en !== 1'b0 || s_data_TREADY !== 1'b0 || tail_TREADY !== 1'b0 || elem_count !== '0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset: en=%b rdy=%b tail_rdy=%b cnt=%0d busy=%b required 0 0 0 0 1",
               chain_en, s_data_TREADY, tail_TREADY, elem_count, busy);
    end
    step();
    rst_n = 1'b1;
    step();
    // stale tail TLAST during CLEAR must be ignored
    reg_TDATA   = {32'd9, 32'd9, 32'd9, 32'd9};
    tail_TVALID = 1'b1;
    tail_TLAST  = 1'b1;
    #1;
    n_vec++;
    if (chain_clear !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset_clear: clear=%b required 1", chain_clear);
    end
    step();
    step();
    tail_TVALID = 1'b0;
    tail_TLAST  = 1'b0;
    n = 0;
    seen = 0;
    #1;
    while (s_data_TREADY !== 1'b1 && n < 40) begin
      if (m_result_TVALID === 1'b1) seen++;
      step();
      n++;
    end
    n_vec++;
    if (seen !== 0 || s_data_TREADY !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset_discard: result cycles %0d rdy=%b required 0 1", seen, s_data_TREADY);
    end
    send_beat(1, 1'b0, w);
    send_beat(2, 1'b0, w);
    send_beat(3, 1'b1, w);
    drain(3, 2, 1, 0);
    expect_results("fresh", 3, 2, 1, 0, 3, 4'b1111);
  endtask

  initial begin
    rst_n           = 1'b0;
    s_data_TDATA    = '0;
    s_data_TVALID   = 1'b0;
    s_data_TLAST    = 1'b0;
    chain_TREADY    = 1'b1;
    tail_TVALID     = 1'b0;
    tail_TLAST      = 1'b0;
    reg_TDATA       = '0;
    m_result_TREADY = 1'b1;
    test_reset();
    test_basic();
    test_short();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/top_k_ctrl.md
# top_k_ctrl

Sequencer for a chain of K top-k cells: it clears the chain, forwards one query stream into the chain head, waits for the stream to drain out of the chain tail, then snapshots the K cell registers and emits them as a K-beat result stream, largest first. It sits between the upstream AXI4-Stream source and the top-k cell chain in the user kernel, and re-arms itself automatically for the next query.

## Interface
- `K`, 8: number of cells in the chain (≥2).
- `INTEGER_SIZE`, 32: data width.
- `CNT_WIDTH`, 32: element counter width.

Ports:
- `clk` in 1: single clock, all logic rising-edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `s_data_TDATA` in INTEGER_SIZE: query element.
- `s_data_TVALID` in 1: element valid.
- `s_data_TLAST` in 1: last element of the query.
- `s_data_TREADY` out 1: element accepted.
- `chain_en` out 1: enable to every cell.
- `chain_clear` out 1: clear into cell 0.
- `chain_TDATA` out INTEGER_SIZE: data to cell 0.
- `chain_TVALID` out 1: valid to cell 0.
- `chain_TLAST` out 1: last flag to cell 0.
- `chain_TREADY` in 1: ready from cell 0.
- `tail_TVALID` in 1: valid from cell K-1.
- `tail_TLAST` in 1: last flag from cell K-1.
- `tail_TREADY` out 1: ready to cell K-1.
- `reg_TDATA` in K*INTEGER_SIZE: cell registers, cell i at bits [i*INTEGER_SIZE +: INTEGER_SIZE]. Cell 0 holds the maximum.
- `m_result_TDATA` out INTEGER_SIZE: result value.
- `m_result_TVALID` out 1: result valid.
- `m_result_TLAST` out 1: last result beat.
- `m_result_TREADY` in 1: downstream ready.
- `elem_count` out CNT_WIDTH: elements in the last completed query.
- `busy` out 1: high in every state except STREAM-waiting-for-first-beat.

## Operation
- FSM states and transitions:
  - CLEAR → STREAM after the clear wait.
  - STREAM → DRAIN on an accepted beat with TLAST.
  - DRAIN → OUTPUT on `tail_TVALID && tail_TLAST`.
  - OUTPUT → CLEAR on acceptance of beat K-1.
- CLEAR:
  - `chain_clear`=1 on the first CLEAR cycle only.
  - Wait counter runs 2*K+2 cycles; the clear propagates 2 cycles per cell.
  - Element counter resets to 0.
- STREAM:
  - `chain_TDATA`/`chain_TLAST` = `s_data_TDATA`/`s_data_TLAST` (combinational).
  - `chain_TVALID` = `s_data_TVALID`.
  - `s_data_TREADY` = `chain_TREADY`.
  - Accepted beat = `s_data_TVALID && s_data_TREADY`. It increments the running counter, saturating at 2^CNT_WIDTH-1.
- DRAIN:
  - `s_data_TREADY`=0, `chain_TVALID`=0.
  - Wait for `tail_TVALID && tail_TLAST`. Tail beats without TLAST are discarded.
  - On the tail-TLAST cycle: capture all K `reg_TDATA` words into the snapshot, load `elem_count` from the running counter, and set index=0.
- OUTPUT:
  - `m_result_TDATA` = snapshot[index], `m_result_TVALID`=1.
  - `m_result_TLAST` = (index==K-1).
  - Index increments on `m_result_TVALID && m_result_TREADY`.
- Outside STREAM: `s_data_TREADY`=0 and `chain_TVALID`=0.
- `tail_TREADY`=1 in every state except reset. The chain must never stall on the tail.
- `chain_en`=1 except while `rst_n`=0.
- A query with fewer than K elements outputs its elements, then zeros: cleared cells hold 0, and values compare unsigned.
- A TLAST on the first beat is a valid 1-element query.

## Timing
- Reset (`rst_n`=0 at a clock edge) sets:
  - state=CLEAR, wait counter=0.
  - `chain_en`=0, `chain_clear`=0, `s_data_TREADY`=0, `chain_TVALID`=0, `tail_TREADY`=0.
  - `m_result_TVALID`=0, `m_result_TLAST`=0, `m_result_TDATA`=0.
  - `elem_count`=0, `busy`=1, snapshot=0.
- `chain_clear` pulses on the first cycle after `rst_n` rises.
- Reset mid-query: the in-flight query is discarded, no result is emitted, and the next cycle shows reset values.
- `s_data_TREADY` first rises 2*K+3 cycles after the `chain_clear` pulse.
- Result beat 0 is valid the cycle after the tail-TLAST cycle.
- Back-to-back queries: the next `chain_clear` pulse occurs the cycle after result beat K-1 is accepted.
- Output stall: while `m_result_TREADY`=0, TDATA, TLAST and index are held stable. TVALID never drops before acceptance.
- Snapshot register changes after capture do not affect output.
- A tail TLAST during CLEAR or STREAM (stale from a previous query) is ignored. Only DRAIN samples it.

## Test plan
- **Reset and clear, K=4:**
  - Release `rst_n` → `chain_clear` is high exactly one cycle, with `chain_en`=1 in that cycle.
  - `s_data_TREADY` rises 11 cycles after the clear pulse.
  - All outputs hold reset values while `rst_n`=0.
- **Basic query, K=4:** stream 5,9,1,7,3,8 (TLAST on 8) with downstream always ready → result 9,8,7,5, TLAST on 5, `elem_count`=6.
- **Short query, K=4:** stream 4,2 → result 4,2,0,0, `elem_count`=2.
- **Backpressure:**
  - Toggle `m_result_TREADY` 1-0-0-1 during OUTPUT → each beat is held until accepted and the order is unchanged.
  - Drop `chain_TREADY` mid-stream → no beat is accepted or counted while it is low.
- **Back-to-back queries:**
  - Stream query A (10,20), then immediately B (3).
  - A results 20,10,0,0; B results 3,0,0,0.
  - No A value leaks into B, and B beats stall (TREADY=0) until the re-clear completes.
- **Reset mid-query:**
  - Assert `rst_n`=0 after 3 of 6 beats → no result emitted.
  - A fresh query 1,2,3 then yields 3,2,1,0.
